dmem_arbiter: RTL

//  Shares the single-port data memory between two requesters: port 0 (pipeline MEM

---
 rtl/dmem_arbiter_if.sv | 12 +
 rtl/dmem_arbiter.sv | 59 +++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/grant/read-return bundle
interface dmem_arbiter_if #(parameter int XW = 32, parameter int DW = 32);
    logic          req;
    logic          we;
    logic [XW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between two requesters
module dmem_arbiter #(
    parameter int XW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave m0,
    dmem_arbiter_if.slave m1,
    output logic [XW-1:0] mem_x,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, RD, WR, WREC} state_t;
    state_t     state;
    logic       owner;
    logic [3:0] starve;
    logic       open, g0, g1;
    assign open   = rst_n && state != WR;
    assign g1     = open && m1.req && (!m0.req || starve == 4'(STARVE_MAX));
    assign g0     = open && m0.req && !g1;
    assign m0.gnt = g0;
    assign m1.gnt = g1;
    assign mem_we = state == WR;
    // access FSM: latch the winner, force WREC after every WR, track port-1 starvation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            starve  <= 4'd0;
            mem_x   <= '0;
            mem_din <= '0;
        end else begin
            state  <= (g0 || g1) ? ((g1 ? m1.we : m0.we) ? WR : RD) : (state == WR ? WREC : IDLE);
            starve <= (m1.req && !g1) ? (starve == 4'(STARVE_MAX) ? starve : starve + 4'd1) : 4'd0;
            if (g0 || g1) begin
                owner   <= g1;
                mem_x   <= g1 ? m1.addr : m0.addr;
                mem_din <= g1 ? m1.wdata : m0.wdata;
            end
        end
    end
    // read return: capture memory output at the end of RD for the owning port only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
        end else begin
            m0.rvalid <= state == RD && !owner;
            m1.rvalid <= state == RD && owner;
            if (state == RD && !owner) m0.rdata <= mem_dout;
            if (state == RD && owner) m1.rdata <= mem_dout;
        end
    end
endmodule
